// File: rtl/weight_fetch_arbiter.sv
// weight_fetch_arbiter
//   Shares one memory read channel between the RDN and DNN weight loaders.
//   Each granted request fetches one 512-bit line. The line is split into
//   eight 64-bit words and delivered to the granted loader with a one-cycle
//   valid pulse. When both loaders contend, grants go round-robin.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   begin_rdn_load / begin_dnn_load     arm loader, capture base pointer
//   rdn_base_addr / dnn_base_addr       base pointer for the begin pulse
//   rdnReqWeightMem / dnnReqWeightMem   loader wants its next line (level)
//   doneWeightRdn / doneWeightDnn       loader finished, disarm (pulse)
//   buffer_addr_valid                   memory accepted the read address
//   data_valid, read_data               returned 512-bit line
//   address, read_request_valid         registered read request
//   rdn_weights / dnn_weights           registered weight words [7:0][63:0]
//   rdn_weights_vld / dnn_weights_vld   one-cycle delivery pulse
//   rdn_busy / dnn_busy                 loader armed
module weight_fetch_arbiter #(
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             begin_rdn_load,
  input  logic             begin_dnn_load,
  input  logic [31:0]      rdn_base_addr,
  input  logic [31:0]      dnn_base_addr,
  input  logic             rdnReqWeightMem,
  input  logic             dnnReqWeightMem,
  input  logic             doneWeightRdn,
  input  logic             doneWeightDnn,
  input  logic             buffer_addr_valid,
  input  logic             data_valid,
  input  logic [511:0]     read_data,
  output logic [31:0]      address,
  output logic             read_request_valid,
  output logic [7:0][63:0] rdn_weights,
  output logic [7:0][63:0] dnn_weights,
  output logic             rdn_weights_vld,
  output logic             dnn_weights_vld,
  output logic             rdn_busy,
  output logic             dnn_busy
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned N_WORDS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_DELIVER
  } state_t;

  // Loader encoding for owner / last_grant
  localparam logic SEL_RDN = 1'b0;
  localparam logic SEL_DNN = 1'b1;

  state_t                           state_q, state_nxt;
  logic                             last_grant_q, last_grant_nxt;
  logic                             owner_q, owner_nxt;
  logic                             abort_q, abort_nxt;
  logic                             rdn_armed_q, rdn_armed_nxt;
  logic                             dnn_armed_q, dnn_armed_nxt;
  logic [ADDR_W-1:0]                rdn_ptr_q, rdn_ptr_nxt;
  logic [ADDR_W-1:0]                dnn_ptr_q, dnn_ptr_nxt;
  logic [ADDR_W-1:0]                address_q, address_nxt;
  logic                             rrv_q, rrv_nxt;
  logic [N_WORDS-1:0][WORD_W-1:0]   rdn_w_q, rdn_w_nxt;
  logic [N_WORDS-1:0][WORD_W-1:0]   dnn_w_q, dnn_w_nxt;
  logic                             rdn_vld_q, rdn_vld_nxt;
  logic                             dnn_vld_q, dnn_vld_nxt;

  logic rdn_elig, dnn_elig;
  logic rdn_event, dnn_event, owner_event;
  logic pick;

  // Eligibility and abort-triggering events
  always_comb begin
    rdn_elig    = rdnReqWeightMem & rdn_armed_q & ~doneWeightRdn;
    dnn_elig    = dnnReqWeightMem & dnn_armed_q & ~doneWeightDnn;
    rdn_event   = begin_rdn_load | doneWeightRdn;
    dnn_event   = begin_dnn_load | doneWeightDnn;
    owner_event = (owner_q == SEL_DNN) ? dnn_event : rdn_event;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state_q;
    last_grant_nxt = last_grant_q;
    owner_nxt      = owner_q;
    abort_nxt      = abort_q;
    rdn_armed_nxt  = rdn_armed_q;
    dnn_armed_nxt  = dnn_armed_q;
    rdn_ptr_nxt    = rdn_ptr_q;
    dnn_ptr_nxt    = dnn_ptr_q;
    address_nxt    = address_q;
    rrv_nxt        = rrv_q;
    rdn_w_nxt      = rdn_w_q;
    dnn_w_nxt      = dnn_w_q;
    rdn_vld_nxt    = 1'b0;
    dnn_vld_nxt    = 1'b0;
    pick           = SEL_RDN;

    // Begin has priority over done for the same loader
    if (begin_rdn_load) begin
      rdn_armed_nxt = 1'b1;
      rdn_ptr_nxt   = rdn_base_addr;
    end else if (doneWeightRdn) begin
      rdn_armed_nxt = 1'b0;
    end
    if (begin_dnn_load) begin
      dnn_armed_nxt = 1'b1;
      dnn_ptr_nxt   = dnn_base_addr;
    end else if (doneWeightDnn) begin
      dnn_armed_nxt = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rdn_elig || dnn_elig) begin
          // Tie goes to the loader that was not granted last
          pick           = (rdn_elig && dnn_elig) ? ~last_grant_q : dnn_elig;
          owner_nxt      = pick;
          last_grant_nxt = pick;
          abort_nxt      = 1'b0;
          rrv_nxt        = 1'b1;
          address_nxt    = (pick == SEL_DNN) ? dnn_ptr_nxt : rdn_ptr_nxt;
          state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (owner_event) abort_nxt = 1'b1;
        if (buffer_addr_valid) begin
          rrv_nxt   = 1'b0;
          state_nxt = S_WAIT_DATA;
        end
      end

      S_WAIT_DATA: begin
        if (owner_event) abort_nxt = 1'b1;
        if (data_valid) begin
          state_nxt = S_DELIVER;
          // Delivery is decided here so vld lines up with DELIVER
          if (!(abort_q || owner_event)) begin
            if (owner_q == SEL_DNN) begin
              dnn_w_nxt   = read_data;
              dnn_vld_nxt = 1'b1;
            end else begin
              rdn_w_nxt   = read_data;
              rdn_vld_nxt = 1'b1;
            end
          end
        end
      end

      S_DELIVER: begin
        abort_nxt = 1'b0;
        state_nxt = S_IDLE;
        // An event this cycle either reloads the pointer or disarms the loader
        if (!(abort_q || owner_event)) begin
          if (owner_q == SEL_DNN) dnn_ptr_nxt = dnn_ptr_q + ADDR_W'(LINE_BYTES);
          else                    rdn_ptr_nxt = rdn_ptr_q + ADDR_W'(LINE_BYTES);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= SEL_DNN;
      owner_q      <= SEL_RDN;
      abort_q      <= 1'b0;
      rdn_armed_q  <= 1'b0;
      dnn_armed_q  <= 1'b0;
      rdn_ptr_q    <= '0;
      dnn_ptr_q    <= '0;
      address_q    <= '0;
      rrv_q        <= 1'b0;
      rdn_w_q      <= '0;
      dnn_w_q      <= '0;
      rdn_vld_q    <= 1'b0;
      dnn_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      last_grant_q <= last_grant_nxt;
      owner_q      <= owner_nxt;
      abort_q      <= abort_nxt;
      rdn_armed_q  <= rdn_armed_nxt;
      dnn_armed_q  <= dnn_armed_nxt;
      rdn_ptr_q    <= rdn_ptr_nxt;
      dnn_ptr_q    <= dnn_ptr_nxt;
      address_q    <= address_nxt;
      rrv_q        <= rrv_nxt;
      rdn_w_q      <= rdn_w_nxt;
      dnn_w_q      <= dnn_w_nxt;
      rdn_vld_q    <= rdn_vld_nxt;
      dnn_vld_q    <= dnn_vld_nxt;
    end
  end

  assign address            = address_q;
  assign read_request_valid = rrv_q;
  assign rdn_weights        = rdn_w_q;
  assign dnn_weights        = dnn_w_q;
  assign rdn_weights_vld    = rdn_vld_q;
  assign dnn_weights_vld    = dnn_vld_q;
  assign rdn_busy           = rdn_armed_q;
  assign dnn_busy           = dnn_armed_q;

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Directed self-checking bench for weight_fetch_arbiter.
module tb_weight_fetch_arbiter;

  logic             clk;
  logic             rst_n;
  logic             begin_rdn_load, begin_dnn_load;
  logic [31:0]      rdn_base_addr, dnn_base_addr;
  logic             rdnReqWeightMem, dnnReqWeightMem;
  logic             doneWeightRdn, doneWeightDnn;
  logic             buffer_addr_valid;
  logic             data_valid;
  logic [511:0]     read_data;
  logic [31:0]      address;
  logic             read_request_valid;
  logic [7:0][63:0] rdn_weights, dnn_weights;
  logic             rdn_weights_vld, dnn_weights_vld;
  logic             rdn_busy, dnn_busy;

  int errors = 0;
  int checks = 0;

  weight_fetch_arbiter #(.LINE_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .begin_rdn_load(begin_rdn_load), .begin_dnn_load(begin_dnn_load),
    .rdn_base_addr(rdn_base_addr), .dnn_base_addr(dnn_base_addr),
    .rdnReqWeightMem(rdnReqWeightMem), .dnnReqWeightMem(dnnReqWeightMem),
    .doneWeightRdn(doneWeightRdn), .doneWeightDnn(doneWeightDnn),
    .buffer_addr_valid(buffer_addr_valid), .data_valid(data_valid),
    .read_data(read_data), .address(address),
    .read_request_valid(read_request_valid),
    .rdn_weights(rdn_weights), .dnn_weights(dnn_weights),
    .rdn_weights_vld(rdn_weights_vld), .dnn_weights_vld(dnn_weights_vld),
    .rdn_busy(rdn_busy), .dnn_busy(dnn_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line k carries word i = k*8 + i
  function automatic logic [511:0] mk_line(input int k);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = 64'(k * 8 + i);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    begin_rdn_load = 0; begin_dnn_load = 0;
    rdn_base_addr = '0; dnn_base_addr = '0;
    rdnReqWeightMem = 0; dnnReqWeightMem = 0;
    doneWeightRdn = 0; doneWeightDnn = 0;
    buffer_addr_valid = 0; data_valid = 0; read_data = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Memory responder for one transaction. inj: 1 = doneWeightDnn, 2 = begin_dnn_load
  // pulsed in the first WAIT_DATA cycle. Returns in the DELIVER cycle.
  task automatic serve(input int ad, input int dd, input int inj, input logic [511:0] line,
                       output logic [31:0] addr, output bit stable, output bit got_rdn,
                       output bit got_dnn, output int waited, output bit tmo);
    addr = '0; stable = 1; got_rdn = 0; got_dnn = 0; waited = 0; tmo = 0;
    step(); waited = 1;
    while (read_request_valid !== 1'b1 && waited < 20) begin
      step(); waited++;
    end
    if (read_request_valid !== 1'b1) begin
      tmo = 1;
      return;
    end
    addr = address;
    repeat (ad) begin
      step();
      if (read_request_valid !== 1'b1 || address !== addr) stable = 0;
    end
    buffer_addr_valid = 1; step(); buffer_addr_valid = 0;
    if (read_request_valid !== 1'b0) stable = 0;
    if (inj == 1) doneWeightDnn = 1;
    if (inj == 2) begin_dnn_load = 1;
    repeat (dd) begin
      step();
      doneWeightDnn = 0; begin_dnn_load = 0;
      if (rdn_weights_vld || dnn_weights_vld) stable = 0;
    end
    data_valid = 1; read_data = line;
    step();
    data_valid = 0; doneWeightDnn = 0; begin_dnn_load = 0;
    got_rdn = rdn_weights_vld;
    got_dnn = dnn_weights_vld;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_address: got %h want 0", address); end
    checks++; if (read_request_valid !== 1'b0) begin errors++; $display("FAIL reset_rrv: got %b want 0", read_request_valid); end
    checks++; if (rdn_weights_vld !== 1'b0 || dnn_weights_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b%b want 00", rdn_weights_vld, dnn_weights_vld); end
    checks++; if (rdn_busy !== 1'b0 || dnn_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", rdn_busy, dnn_busy); end
    checks++; if (rdn_weights !== '0 || dnn_weights !== '0) begin errors++; $display("FAIL reset_weights: nonzero after reset"); end
  endtask

  task automatic test_single();
    logic [31:0] a; bit st, gr, gd, t; int w; bit seen;
    do_reset();
    rdn_base_addr = 32'h1000; begin_rdn_load = 1; step(); begin_rdn_load = 0;
    checks++; if (rdn_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", rdn_busy); end
    rdnReqWeightMem = 1;
    for (int k = 0; k < 3; k++) begin
      serve(0, 0, 0, mk_line(k), a, st, gr, gd, w, t);
      if (k == 2) rdnReqWeightMem = 0;
      checks++; if (t) begin errors++; $display("FAIL single_timeout: line %0d no request", k); end
      checks++; if (a !== 32'h1000 + 32'(k * 64)) begin errors++; $display("FAIL single_addr%0d: got %h want %h", k, a, 32'h1000 + 32'(k * 64)); end
      checks++; if (!gr || gd) begin errors++; $display("FAIL single_vld%0d: got rdn=%b dnn=%b want rdn=1 dnn=0", k, gr, gd); end
      checks++; if (rdn_weights !== mk_line(k)) begin errors++; $display("FAIL single_words%0d: got %h want %h", k, rdn_weights, mk_line(k)); end
      checks++; if (dnn_weights !== '0) begin errors++; $display("FAIL single_dnn_untouched%0d: got %h want 0", k, dnn_weights); end
      checks++; if (w !== ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL single_latency%0d: got %0d want %0d", k, w, (k == 0) ? 1 : 2); end
    end
    seen = 0;
    repeat (5) begin step(); if (read_request_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL single_stop: got request after req dropped, want none"); end
    doneWeightRdn = 1; step(); doneWeightRdn = 0;
    checks++; if (rdn_busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b want 0", rdn_busy); end
  endtask

  task automatic test_contention();
    logic [31:0] a; bit st, gr, gd, t; int w;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h0; exp_a[1] = 32'h8000; exp_a[2] = 32'h40; exp_a[3] = 32'h8040;
    do_reset();
    rdn_base_addr = 32'h0; dnn_base_addr = 32'h8000;
    begin_rdn_load = 1; begin_dnn_load = 1; step();
    begin_rdn_load = 0; begin_dnn_load = 0;
    rdnReqWeightMem = 1; dnnReqWeightMem = 1;
    for (int k = 0; k < 4; k++) begin
      serve(0, 0, 0, mk_line(10 + k), a, st, gr, gd, w, t);
      if (k == 3) begin rdnReqWeightMem = 0; dnnReqWeightMem = 0; end
      checks++; if (t) begin errors++; $display("FAIL cont_timeout: grant %0d", k); end
      checks++; if (a !== exp_a[k]) begin errors++; $display("FAIL cont_addr%0d: got %h want %h", k, a, exp_a[k]); end
      checks++; if (gr !== (k % 2 == 0) || gd !== (k % 2 == 1)) begin errors++; $display("FAIL cont_owner%0d: got rdn=%b dnn=%b want rdn=%b", k, gr, gd, (k % 2 == 0)); end
      if (k % 2 == 0) begin
        checks++; if (rdn_weights !== mk_line(10 + k)) begin errors++; $display("FAIL cont_rdn_words%0d: got %h want %h", k, rdn_weights, mk_line(10 + k)); end
      end else begin
        checks++; if (dnn_weights !== mk_line(10 + k)) begin errors++; $display("FAIL cont_dnn_words%0d: got %h want %h", k, dnn_weights, mk_line(10 + k)); end
      end
    end
    doneWeightRdn = 1; doneWeightDnn = 1; step(); doneWeightRdn = 0; doneWeightDnn = 0;
  endtask

  task automatic test_stall();
    logic [31:0] a; bit st, gr, gd, t; int w; bit seen;
    do_reset();
    rdn_base_addr = 32'h2000; begin_rdn_load = 1; step(); begin_rdn_load = 0;
    rdnReqWeightMem = 1;
    serve(5, 7, 0, mk_line(30), a, st, gr, gd, w, t);
    rdnReqWeightMem = 0;
    checks++; if (t) begin errors++; $display("FAIL stall_timeout: no request"); end
    checks++; if (a !== 32'h2000) begin errors++; $display("FAIL stall_addr: got %h want 2000", a); end
    checks++; if (!st) begin errors++; $display("FAIL stall_stable: request not stable or early vld, want stable"); end
    checks++; if (!gr || gd) begin errors++; $display("FAIL stall_vld: got rdn=%b dnn=%b want rdn=1 dnn=0", gr, gd); end
    checks++; if (rdn_weights !== mk_line(30)) begin errors++; $display("FAIL stall_words: got %h want %h", rdn_weights, mk_line(30)); end
    step();
    data_valid = 1; read_data = mk_line(99);
    seen = 0;
    repeat (2) begin step(); if (rdn_weights_vld || dnn_weights_vld || read_request_valid) seen = 1; end
    data_valid = 0;
    step(); if (rdn_weights_vld || dnn_weights_vld) seen = 1;
    checks++; if (seen) begin errors++; $display("FAIL stall_stray_vld: got activity on stray data_valid, want none"); end
    checks++; if (rdn_weights !== mk_line(30)) begin errors++; $display("FAIL stall_stray_words: got %h want %h", rdn_weights, mk_line(30)); end
  endtask

  task automatic test_abort();
    logic [31:0] a; bit st, gr, gd, t; int w; bit seen;
    do_reset();
    dnn_base_addr = 32'h3000; begin_dnn_load = 1; step(); begin_dnn_load = 0;
    dnn_base_addr = 32'h200;
    dnnReqWeightMem = 1;
    serve(0, 2, 2, mk_line(40), a, st, gr, gd, w, t);
    checks++; if (a !== 32'h3000) begin errors++; $display("FAIL abort_begin_addr: got %h want 3000", a); end
    checks++; if (gd || gr) begin errors++; $display("FAIL abort_begin_vld: got rdn=%b dnn=%b want 00", gr, gd); end
    checks++; if (dnn_weights !== '0) begin errors++; $display("FAIL abort_begin_words: got %h want 0", dnn_weights); end
    serve(0, 0, 0, mk_line(41), a, st, gr, gd, w, t);
    checks++; if (t) begin errors++; $display("FAIL abort_reload_timeout: no request"); end
    checks++; if (a !== 32'h200) begin errors++; $display("FAIL abort_reload_addr: got %h want 200", a); end
    checks++; if (!gd || gr) begin errors++; $display("FAIL abort_reload_vld: got rdn=%b dnn=%b want dnn=1", gr, gd); end
    checks++; if (dnn_weights !== mk_line(41)) begin errors++; $display("FAIL abort_reload_words: got %h want %h", dnn_weights, mk_line(41)); end
    serve(0, 2, 1, mk_line(42), a, st, gr, gd, w, t);
    checks++; if (a !== 32'h240) begin errors++; $display("FAIL abort_done_addr: got %h want 240", a); end
    checks++; if (gd || gr) begin errors++; $display("FAIL abort_done_vld: got rdn=%b dnn=%b want 00", gr, gd); end
    checks++; if (dnn_weights !== mk_line(41)) begin errors++; $display("FAIL abort_done_words: got %h want %h", dnn_weights, mk_line(41)); end
    checks++; if (dnn_busy !== 1'b0) begin errors++; $display("FAIL abort_done_busy: got %b want 0", dnn_busy); end
    seen = 0;
    repeat (6) begin step(); if (read_request_valid || dnn_weights_vld) seen = 1; end
    dnnReqWeightMem = 0;
    checks++; if (seen) begin errors++; $display("FAIL abort_done_idle: got request after disarm, want none"); end
  endtask

  task automatic test_unarmed_wrap();
    logic [31:0] a; bit st, gr, gd, t; int w; bit seen;
    do_reset();
    rdnReqWeightMem = 1;
    seen = 0;
    repeat (8) begin step(); if (read_request_valid) seen = 1; end
    rdnReqWeightMem = 0;
    checks++; if (seen) begin errors++; $display("FAIL unarmed_req: got read_request_valid, want none"); end
    rdn_base_addr = 32'hFFFF_FFC0; begin_rdn_load = 1; step(); begin_rdn_load = 0;
    rdnReqWeightMem = 1;
    serve(0, 0, 0, mk_line(50), a, st, gr, gd, w, t);
    checks++; if (a !== 32'hFFFF_FFC0) begin errors++; $display("FAIL wrap_addr0: got %h want ffffffc0", a); end
    serve(0, 0, 0, mk_line(51), a, st, gr, gd, w, t);
    rdnReqWeightMem = 0;
    checks++; if (a !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 0", a); end
    checks++; if (!gr || rdn_weights !== mk_line(51)) begin errors++; $display("FAIL wrap_vld: got vld=%b words %h want vld=1 %h", gr, rdn_weights, mk_line(51)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; bit st, gr, gd, t; int w;
    do_reset();
    rdn_base_addr = 32'h5000; begin_rdn_load = 1; step(); begin_rdn_load = 0;
    rdnReqWeightMem = 1;
    step();
    checks++; if (read_request_valid !== 1'b1 || address !== 32'h5000) begin errors++; $display("FAIL midrst_issue: got rrv=%b addr=%h want 1 5000", read_request_valid, address); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (read_request_valid !== 1'b0) begin errors++; $display("FAIL midrst_rrv: got %b want 0", read_request_valid); end
    checks++; if (rdn_busy !== 1'b0 || dnn_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b%b want 00", rdn_busy, dnn_busy); end
    rdnReqWeightMem = 0;
    step();
    rst_n = 1'b1;
    data_valid = 1; read_data = mk_line(60);
    step(); data_valid = 0;
    step();
    checks++; if (rdn_weights_vld || rdn_weights !== '0) begin errors++; $display("FAIL midrst_late_data: got vld=%b words %h want 0", rdn_weights_vld, rdn_weights); end
    rdn_base_addr = 32'h6000; begin_rdn_load = 1; step(); begin_rdn_load = 0;
    rdnReqWeightMem = 1;
    serve(0, 0, 0, mk_line(61), a, st, gr, gd, w, t);
    rdnReqWeightMem = 0;
    checks++; if (t || a !== 32'h6000) begin errors++; $display("FAIL midrst_after_addr: got %h tmo=%b want 6000", a, t); end
    checks++; if (!gr || rdn_weights !== mk_line(61)) begin errors++; $display("FAIL midrst_after_vld: got vld=%b words %h want 1 %h", gr, rdn_weights, mk_line(61)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_abort();
    test_unarmed_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
